// File: rtl/draw_seq_pkg.sv
// Shared types and constants for the draw sequencer.
package draw_seq_pkg;

  typedef enum logic [2:0] {
    ERASE,
    DRAW,
    GAP,
    SETTLE,
    DELAY,
    UPDATE
  } drawState_t;

  localparam int unsigned OBJ_NONE = 0;

  // Counter width for a count of n, never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_seq_next_obj.sv
// Combinational priority encoder: lowest enabled slot at or above startIdx.
module draw_seq_next_obj
  import draw_seq_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS = 6,
  parameter int unsigned OBJ_W       = 4
) (
  input  logic [NUM_OBJECTS-1:0] objectEnable,
  input  logic [OBJ_W-1:0]       startIdx,
  output logic [OBJ_W-1:0]       nextIdx_c,
  output logic                   found_c
);

  // Scan downwards so the lowest qualifying slot is the last one written.
  always_comb begin
    found_c   = 1'b0;
    nextIdx_c = OBJ_W'(OBJ_NONE);
    for (int i = NUM_OBJECTS - 1; i >= 0; i--) begin
      if (objectEnable[i] && (OBJ_W'(i) >= startIdx)) begin
        found_c   = 1'b1;
        nextIdx_c = OBJ_W'(i);
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Erase / draw-objects / frame-delay / update sequencer for a VGA game loop.
// Optional pause of the inter-update delay with DRAW_SEQUENCER_PAUSE_EN.
module draw_sequencer
  import draw_seq_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS       = 6,
  parameter int unsigned OBJ_W             = 4,
  parameter int unsigned FRAME_TICKS       = 833334,
  parameter int unsigned FRAMES_PER_UPDATE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done_drawing,
  input  logic                   done_erasing,
  input  logic [NUM_OBJECTS-1:0] object_enable,
  input  logic                   pause,
  output logic [OBJ_W-1:0]       object_to_draw,
  output logic                   vga_plot,
  output logic                   in_erase_state,
  output logic                   in_update_state
);

  localparam int unsigned TICK_W  = cntWidth(FRAME_TICKS);
  localparam int unsigned FRAME_W = cntWidth(FRAMES_PER_UPDATE);
  localparam logic [TICK_W-1:0]  TICK_LOAD  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAMES_PER_UPDATE - 1);

  drawState_t         state, stateNext;
  logic [OBJ_W-1:0]   slot, slotNext;
  logic [TICK_W-1:0]  tick, tickNext;
  logic [FRAME_W-1:0] frame, frameNext;

  logic [OBJ_W-1:0]   searchStart;
  logic [OBJ_W-1:0]   foundSlot;
  logic               found;
  logic               holdDelay;

  logic               plotNext, eraseNext, updateNext;
  logic [OBJ_W-1:0]   objNext;

`ifdef DRAW_SEQUENCER_PAUSE_EN
  assign holdDelay = pause;
`else
  logic unusedPause;
  assign unusedPause = pause;
  assign holdDelay   = 1'b0;
`endif

  // ERASE searches from slot 0; GAP searches above the slot just drawn.
  assign searchStart = (state == GAP) ? (slot + OBJ_W'(1)) : '0;

  draw_seq_next_obj #(
    .NUM_OBJECTS(NUM_OBJECTS),
    .OBJ_W      (OBJ_W)
  ) uNextObj (
    .objectEnable(object_enable),
    .startIdx    (searchStart),
    .nextIdx_c   (foundSlot),
    .found_c     (found)
  );

  always_comb begin
    stateNext  = state;
    slotNext   = slot;
    tickNext   = tick;
    frameNext  = frame;
    plotNext   = 1'b0;
    eraseNext  = 1'b0;
    updateNext = 1'b0;
    objNext    = OBJ_W'(OBJ_NONE);

    case (state)
      ERASE: begin
        if (done_erasing) begin
          if (found) begin
            stateNext = DRAW;
            slotNext  = foundSlot;
          end else begin
            stateNext = SETTLE;
          end
        end
      end
      DRAW: begin
        if (done_drawing) stateNext = GAP;
      end
      GAP: begin
        if (found) begin
          stateNext = DRAW;
          slotNext  = foundSlot;
        end else begin
          stateNext = SETTLE;
        end
      end
      SETTLE: begin
        tickNext  = TICK_LOAD;
        frameNext = '0;
        stateNext = DELAY;
      end
      DELAY: begin
        if (!holdDelay) begin
          if (tick != '0) begin
            tickNext = tick - TICK_W'(1);
          end else if (frame != FRAME_LAST) begin
            tickNext  = TICK_LOAD;
            frameNext = frame + FRAME_W'(1);
          end else begin
            stateNext = UPDATE;
          end
        end
      end
      UPDATE: stateNext = ERASE;
      default: stateNext = ERASE;
    endcase

    // Moore decode of the upcoming state so the registered outputs track it.
    case (stateNext)
      ERASE: begin
        plotNext  = 1'b1;
        eraseNext = 1'b1;
      end
      DRAW: begin
        plotNext = 1'b1;
        objNext  = slotNext + OBJ_W'(1);
      end
      UPDATE: updateNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ERASE;
      slot            <= '0;
      tick            <= TICK_LOAD;
      frame           <= '0;
      vga_plot        <= 1'b1;
      in_erase_state  <= 1'b1;
      in_update_state <= 1'b0;
      object_to_draw  <= OBJ_W'(OBJ_NONE);
    end else begin
      state           <= stateNext;
      slot            <= slotNext;
      tick            <= tickNext;
      frame           <= frameNext;
      vga_plot        <= plotNext;
      in_erase_state  <= eraseNext;
      in_update_state <= updateNext;
      object_to_draw  <= objNext;
    end
  end

endmodule
